// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame width and baud divisor helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic bit_tick_c_o,
  output logic tick_next_c_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // tick_next lets the owner register a flag that lines up with the tick cycle
  assign bit_tick_c_o  = (cnt_q == CNT_MAX);
  assign tick_next_c_o = (cnt_d == CNT_MAX);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter triggered by the rising edge of a debounced button level.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned BIT_IDX_W    = 3;
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic                   transmit_q;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   start_c;
  logic                   baud_clr_c;
  logic                   bit_tick_c;
  logic                   tick_next_c;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  assign start_c = transmit & ~transmit_q;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (baud_clr_c),
    .bit_tick_c_o  (bit_tick_c),
    .tick_next_c_o (tick_next_c)
  );

  // Outputs are computed from next-state values so the registers line up with the state
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_clr_c = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_clr_c = 1'b1;
        if (start_c) begin
          shift_d   = data_in;
          bit_idx_d = '0;
          state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^data_in;
`endif
        end
      end
      ST_START: begin
        if (bit_tick_c) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick_c) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick_c) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_tick_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && tick_next_c;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      transmit_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      transmit_q <= transmit;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter at CLKS_PER_BIT=10; honours UART_TX_PARITY_EN.
module tb_uart_transmitter;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  typedef struct {
    logic [7:0] data;
    int         n;
    bit         abort;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       transmit;
  logic [7:0] data_in;
  logic       tx;
  logic       busy;
  logic       done;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   idle_err = 0;
  bit   in_frame = 1'b0;
  exp_t exp_q[$];

  uart_transmitter #(
    .CLK_FREQ  (1000),
    .BAUD_RATE (100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .transmit (transmit),
    .data_in  (data_in),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic send(input logic [7:0] d, input bit abort, output int n);
    data_in  = d;
    transmit = 1'b1;
    n        = cyc;
    exp_q.push_back('{data: d, n: n, abort: abort});
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 4 * FRAME; i++) begin
      if (exp_q.size() == 0 && !in_frame && busy !== 1'b1) break;
      tick(1);
    end
    check("drain_timeout", 32'(i >= 4 * FRAME), 32'd0);
  endtask

  // Monitor: pops one expectation per frame and checks it bit period by bit period
  initial begin : monitor
    exp_t e;
    int   wrong;
    int   done_bad;
    bit   aborted;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) continue;
      if (busy !== 1'b1) begin
        if (tx !== 1'b1 || done !== 1'b0) idle_err++;
        continue;
      end
      in_frame = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
        for (int i = 0; i < 2 * FRAME && busy === 1'b1 && rst_n === 1'b1; i++) @(negedge clk);
        in_frame = 1'b0;
        continue;
      end
      e = exp_q.pop_front();
      check("frame_start_cycle", cyc, e.n + 1);
      aborted  = 1'b0;
      done_bad = 0;
      for (int b = 0; b < NBITS && !aborted; b++) begin
        wrong = 0;
        for (int c = 0; c < CPB; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (tx !== exp_bit(e.data, b) || busy !== 1'b1) wrong++;
          if (done !== ((b == NBITS - 1) && (c == CPB - 1))) done_bad++;
        end
        if (!aborted) check($sformatf("bit%0d_wrong_cycles", b), wrong, 0);
      end
      if (aborted) begin
        check("frame_aborted_by_reset", 32'd1, 32'(e.abort));
      end else begin
        check("frame_completed", 32'(e.abort), 32'd0);
        check("done_misplaced_cycles", done_bad, 0);
        @(negedge clk);
        check("busy_after_frame", 32'(busy), 32'd0);
        check("done_after_frame", 32'(done), 32'd0);
      end
      in_frame = 1'b0;
    end
  end

  initial begin : stimulus
    int n;
    rst_n    = 1'b0;
    transmit = 1'b0;
    data_in  = 8'h00;
    tick(3);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick(3);
    check("idle_tx_after_reset", 32'(tx), 32'd1);

    // 0x55 with a short press
    send(8'h55, 1'b0, n);
    tick(3);
    transmit = 1'b0;
    drain();

    // 0xA3 held for 300 cycles: exactly one frame
    tick(5);
    send(8'hA3, 1'b0, n);
    tick(300);
    transmit = 1'b0;
    drain();

    // 0x0F with a second rising edge mid-frame
    tick(5);
    send(8'h0F, 1'b0, n);
    wait_cyc(n + 20);
    transmit = 1'b0;
    wait_cyc(n + 40);
    transmit = 1'b1;
    wait_cyc(n + 50);
    transmit = 1'b0;
    drain();

    // 0xFF with data_in changed after latch
    tick(5);
    send(8'hFF, 1'b0, n);
    wait_cyc(n + 5);
    data_in = 8'h00;
    wait_cyc(n + 10);
    transmit = 1'b0;
    drain();

    // Reset mid-frame
    tick(5);
    send(8'h3C, 1'b1, n);
    wait_cyc(n + 3);
    transmit = 1'b0;
    wait_cyc(n + 35);
    rst_n = 1'b0;
    #1;
    check("midreset_tx", 32'(tx), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(50);
    check("post_reset_tx_idle", 32'(tx), 32'd1);
    check("post_reset_busy", 32'(busy), 32'd0);

    // Rising edge in the done cycle is ignored; a later fresh edge starts a frame
    send(8'h81, 1'b0, n);
    wait_cyc(n + 10);
    transmit = 1'b0;
    wait_cyc(n + FRAME);
    check("done_in_last_cycle", 32'(done), 32'd1);
    transmit = 1'b1;
    wait_cyc(n + FRAME + 15);
    check("done_cycle_edge_ignored", 32'(busy), 32'd0);
    transmit = 1'b0;
    tick(5);
    send(8'h5A, 1'b0, n);
    tick(2);
    transmit = 1'b0;
    drain();

`ifdef UART_TX_PARITY_EN
    tick(5);
    send(8'h07, 1'b0, n);
    tick(2);
    transmit = 1'b0;
    drain();
`endif

    tick(10);
    check("idle_line_errors", idle_err, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
